// File: rtl/serial_resp_transmitter_pkg.sv
// Shared definitions for the serial command processor response path.
// Holds the SOF default, status codes, frame lengths, FSM state encodings,
// the response record payload and a helper for the last byte index of a frame.
package serial_resp_transmitter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WDOG_W = 32;

  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

  localparam logic [BYTE_W-1:0] STATUS_OK       = 8'h00;
  localparam logic [BYTE_W-1:0] STATUS_BAD_CMD  = 8'h01;
  localparam logic [BYTE_W-1:0] STATUS_BAD_ADDR = 8'h02;
  localparam logic [BYTE_W-1:0] STATUS_BAD_CHK  = 8'h03;

  localparam int unsigned FRAME_LEN_OK  = 9;
  localparam int unsigned FRAME_LEN_ERR = 5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_WAIT_COPY = 4'd2,
    S_DRAIN     = 4'd3
  } tx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] cmd;
    logic [BYTE_W-1:0] status;
    logic [BYTE_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } resp_rec_t;

  // Index of the CHK byte: OK frames carry 4 data bytes, error frames none.
  function automatic logic [IDX_W-1:0] last_idx(input logic status_ok);
    return status_ok ? IDX_W'(FRAME_LEN_OK - 1) : IDX_W'(FRAME_LEN_ERR - 1);
  endfunction

endpackage

// File: rtl/serial_frame_checksum.sv
// Running 8-bit modulo-256 sum of frame bytes.
// Ports: clk, rst (async, active-high); clear zeroes the sum; en adds din;
// clear has priority over en. sum is the registered running total.
module serial_frame_checksum
  import serial_resp_transmitter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= BYTE_W'(sum + din);
    end
  end

endmodule

// File: rtl/serial_resp_transmitter.sv
// Response-path framer: latches one response record and sends it byte by
// byte over the quick_rs232 transmit handshake.
//   OK frame    : SOF CMD STATUS ADDR D3 D2 D1 D0 CHK
//   error frame : SOF CMD STATUS ADDR CHK
// Ports: clk, rst (async, active-high); resp_valid/resp_ready/resp_* record
// input; tx_transaction/tx_data/tx_data_ready out and tx_data_copied/tx_busy
// in towards quick_rs232; frame_done/frame_err one-cycle status pulses.
// Optional macro RESP_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES) that aborts
// a stalled frame and pulses frame_err; without it frame_err is tied 0.
module serial_resp_transmitter
  import serial_resp_transmitter_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SOF_BYTE = SOF_DEFAULT
`ifdef RESP_TIMEOUT_EN
  ,
  parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 32'd5000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [BYTE_W-1:0] resp_cmd,
  input  logic [BYTE_W-1:0] resp_status,
  input  logic [BYTE_W-1:0] resp_addr,
  input  logic [DATA_W-1:0] resp_data,
  output logic              tx_transaction,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_data_ready,
  input  logic              tx_data_copied,
  input  logic              tx_busy,
  output logic              frame_done,
  output logic              frame_err
);

  tx_state_e         state;
  resp_rec_t         rec_q;
  logic              rec_ok_q;
  logic [IDX_W-1:0]  byte_idx;
  logic [BYTE_W-1:0] chk_sum;
  logic [BYTE_W-1:0] byte_c;
  logic              accept_c;
  logic              copy_c;
  logic              last_c;
  logic              chk_en_c;
  logic              wdog_hit_c;

  assign accept_c = (state == S_IDLE) && resp_valid && resp_ready;
  assign copy_c   = (state == S_WAIT_COPY) && tx_data_copied;
  assign last_c   = (byte_idx == last_idx(rec_ok_q));
  // SOF and CHK itself stay out of the sum.
  assign chk_en_c = copy_c && (byte_idx != '0) && !last_c;

  // Byte selected by the current index; index 4 is CHK on error frames.
  always_comb begin
    byte_c = '0;
    case (byte_idx)
      4'd0:    byte_c = SOF_BYTE;
      4'd1:    byte_c = rec_q.cmd;
      4'd2:    byte_c = rec_q.status;
      4'd3:    byte_c = rec_q.addr;
      4'd4:    byte_c = rec_ok_q ? rec_q.data[31:24] : chk_sum;
      4'd5:    byte_c = rec_q.data[23:16];
      4'd6:    byte_c = rec_q.data[15:8];
      4'd7:    byte_c = rec_q.data[7:0];
      4'd8:    byte_c = chk_sum;
      default: byte_c = '0;
    endcase
  end

  serial_frame_checksum u_chk (
    .clk   (clk),
    .rst   (rst),
    .clear (accept_c),
    .en    (chk_en_c),
    .din   (tx_data),
    .sum   (chk_sum)
  );

`ifdef RESP_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;

  assign wdog_hit_c = ((state == S_WAIT_COPY) || (state == S_DRAIN)) && !copy_c &&
                      (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 32'd1));

  // Counts stalled cycles; restarts on every accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= wdog_hit_c;
      if (((state != S_WAIT_COPY) && (state != S_DRAIN)) || copy_c || wdog_hit_c) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= WDOG_W'(wdog_q + 32'd1);
      end
    end
  end
`else
  assign wdog_hit_c = 1'b0;
  assign frame_err  = 1'b0;
`endif

  // Frame sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      resp_ready     <= 1'b0;
      tx_transaction <= 1'b0;
      tx_data        <= '0;
      tx_data_ready  <= 1'b0;
      frame_done     <= 1'b0;
      rec_q          <= '0;
      rec_ok_q       <= 1'b0;
      byte_idx       <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            resp_ready <= 1'b0;
            rec_q      <= '{cmd: resp_cmd, status: resp_status, addr: resp_addr, data: resp_data};
            rec_ok_q   <= (resp_status == STATUS_OK);
            byte_idx   <= '0;
            state      <= S_LOAD;
          end else begin
            resp_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          tx_transaction <= 1'b1;
          tx_data        <= byte_c;
          tx_data_ready  <= 1'b1;
          state          <= S_WAIT_COPY;
        end
        S_WAIT_COPY: begin
          if (wdog_hit_c) begin
            tx_data_ready  <= 1'b0;
            tx_transaction <= 1'b0;
            state          <= S_IDLE;
          end else if (tx_data_copied) begin
            tx_data_ready <= 1'b0;
            if (last_c) begin
              state <= S_DRAIN;
            end else begin
              byte_idx <= IDX_W'(byte_idx + 4'd1);
              state    <= S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (wdog_hit_c) begin
            tx_transaction <= 1'b0;
            state          <= S_IDLE;
          end else if (!tx_busy) begin
            tx_transaction <= 1'b0;
            frame_done     <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_resp_transmitter.sv
// Directed bench for serial_resp_transmitter: a table of response records
// with hand-computed frames, plus sequences for back-pressure, back-to-back
// records, reset mid-frame, stray copy pulses and (with RESP_TIMEOUT_EN)
// the watchdog abort.
module tb_serial_resp_transmitter;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  st;
    logic [7:0]  addr;
    logic [31:0] data;
    int          nbytes;
    logic [71:0] exp;      // byte 0 in [71:64]
    int          max_delay;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_cmd;
  logic [7:0]  resp_status;
  logic [7:0]  resp_addr;
  logic [31:0] resp_data;
  logic        tx_transaction;
  logic [7:0]  tx_data;
  logic        tx_data_ready;
  logic        tx_data_copied;
  logic        tx_busy;
  logic        frame_done;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int frames_expected = 0;

`ifdef RESP_TIMEOUT_EN
  serial_resp_transmitter #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(32'd100)) dut (
`else
  serial_resp_transmitter #(.SOF_BYTE(8'hA5)) dut (
`endif
    .clk            (clk),
    .rst            (rst),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_cmd       (resp_cmd),
    .resp_status    (resp_status),
    .resp_addr      (resp_addr),
    .resp_data      (resp_data),
    .tx_transaction (tx_transaction),
    .tx_data        (tx_data),
    .tx_data_ready  (tx_data_ready),
    .tx_data_copied (tx_data_copied),
    .tx_busy        (tx_busy),
    .frame_done     (frame_done),
    .frame_err      (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model: busy for a few cycles after each byte is copied.
  always @(posedge clk) begin
    if (tx_data_copied) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Sends one record and checks every byte. abort_at >= 0 returns as soon
  // as that byte is presented; hold_next keeps resp_valid up with nxt.
  task automatic run_frame(input vec_t v, input int abort_at, input bit hold_next, input vec_t nxt);
    int         waitc;
    int         d;
    logic [7:0] held;
    bit         stable;
    resp_cmd    = v.cmd;
    resp_status = v.st;
    resp_addr   = v.addr;
    resp_data   = v.data;
    resp_valid  = 1'b1;
    waitc = 0;
    while (resp_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_wait_in_bound", 32'(waitc < 200), 32'd1);
    if (waitc >= 200) return;
    @(negedge clk);
    if (hold_next) begin
      resp_cmd    = nxt.cmd;
      resp_status = nxt.st;
      resp_addr   = nxt.addr;
      resp_data   = nxt.data;
    end else begin
      resp_valid = 1'b0;
    end
    check("resp_ready_drop", 32'(resp_ready), 32'd0);
    check("tx_ready_lat1", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    check("tx_ready_lat2", 32'(tx_data_ready), 32'd1);
    for (int i = 0; i < v.nbytes; i++) begin
      waitc = 0;
      while (tx_data_ready !== 1'b1 && waitc < 100) begin
        @(negedge clk);
        check("resp_ready_busy", 32'(resp_ready), 32'd0);
        waitc++;
      end
      check($sformatf("byte%0d_ready_in_bound", i), 32'(waitc < 100), 32'd1);
      if (waitc >= 100) return;
      if (i == abort_at) return;
      check($sformatf("byte%0d", i), 32'(tx_data), 32'(v.exp[71-8*i -: 8]));
      check($sformatf("byte%0d_txn", i), 32'(tx_transaction), 32'd1);
      held   = tx_data;
      stable = 1'b1;
      d = (v.max_delay == 0) ? 0 : int'($urandom_range(v.max_delay, 0));
      repeat (d) begin
        @(negedge clk);
        if (tx_data !== held || tx_data_ready !== 1'b1 || resp_ready !== 1'b0) stable = 1'b0;
      end
      if (d != 0) check($sformatf("byte%0d_held", i), 32'(stable), 32'd1);
      tx_data_copied = 1'b1;
      @(negedge clk);
      tx_data_copied = 1'b0;
      check($sformatf("byte%0d_gap", i), 32'(tx_data_ready), 32'd0);
    end
    waitc = 0;
    while (frame_done !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("frame_done_in_bound", 32'(waitc < 100), 32'd1);
    frames_expected++;
    check("done_after_busy", 32'(busy_cnt), 32'd0);
    check("txn_low_at_done", 32'(tx_transaction), 32'd0);
    check("ready_low_at_done", 32'(resp_ready), 32'd0);
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t none;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{8'h01, 8'h00, 8'h10, 32'hDEADBEEF, 9, 72'hA5_01_00_10_DE_AD_BE_EF_49, 0};
    vecs[1] = '{8'h02, 8'h03, 8'h20, 32'hFFFFFFFF, 5, 72'hA5_02_03_20_25_00_00_00_00, 0};
    vecs[2] = '{8'h01, 8'h00, 8'h10, 32'hDEADBEEF, 9, 72'hA5_01_00_10_DE_AD_BE_EF_49, 50};
    vecs[3] = '{8'h03, 8'h00, 8'h05, 32'h00000000, 9, 72'hA5_03_00_05_00_00_00_00_08, 1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 32'hFFFFFFFF, 9, 72'hA5_FF_00_FF_FF_FF_FF_FF_FA, 3};
    vecs[5] = '{8'h80, 8'h81, 8'h90, 32'h12345678, 5, 72'hA5_80_81_90_91_00_00_00_00, 2};
    none    = vecs[0];

    rst = 1'b1;
    resp_valid = 1'b0;
    resp_cmd = '0;
    resp_status = '0;
    resp_addr = '0;
    resp_data = '0;
    tx_data_copied = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({resp_ready, tx_transaction, tx_data, tx_data_ready, frame_done, frame_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_ready", 32'(resp_ready), 32'd1);

    // Stray copy pulse while idle is ignored.
    tx_data_copied = 1'b1;
    @(negedge clk);
    tx_data_copied = 1'b0;
    @(negedge clk);
    check("stray_copy_idle", 32'({resp_ready, tx_transaction, tx_data_ready}), 32'b100);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], -1, 1'b0, none);

    // Back-to-back: second record waits for the first frame_done.
    run_frame(vecs[1], -1, 1'b1, vecs[3]);
    run_frame(vecs[3], -1, 1'b0, none);

    // Reset while byte 4 is presented.
    run_frame(vecs[0], 4, 1'b0, none);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({resp_ready, tx_transaction, tx_data, tx_data_ready, frame_done, frame_err}), 32'd0);
    @(negedge clk);
    check("reset_hold_outputs", 32'({resp_ready, tx_transaction, tx_data, tx_data_ready, frame_done, frame_err}), 32'd0);
    rst = 1'b0;
    run_frame(vecs[0], -1, 1'b0, none);

`ifdef RESP_TIMEOUT_EN
    begin
      int cyc;
      resp_cmd = 8'h01; resp_status = 8'h00; resp_addr = 8'h10; resp_data = 32'hDEADBEEF;
      resp_valid = 1'b1;
      cyc = 0;
      while (resp_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      @(negedge clk);
      resp_valid = 1'b0;
      cyc = 0;
      while (frame_err !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
      check("timeout_window", 32'(cyc >= 95 && cyc <= 110), 32'd1);
      check("timeout_outputs", 32'({tx_transaction, tx_data_ready, frame_done}), 32'd0);
      @(negedge clk);
      check("timeout_err_pulse", 32'(frame_err), 32'd0);
      check("timeout_idle_ready", 32'(resp_ready), 32'd1);
    end
`endif

    @(negedge clk);
    check("frame_done_count", 32'(done_cnt), 32'(frames_expected));
`ifdef RESP_TIMEOUT_EN
    check("frame_err_count", 32'(err_cnt), 32'd1);
`else
    check("frame_err_count", 32'(err_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
